// File: rtl/regfile_alu_pipe.sv
// rtl/regfile_alu_pipe.sv - two-stage register-file/ALU datapath
// RD stage reads and forwards operands; EX stage computes, writes back and updates flags.
module regfile_alu_pipe #(
   parameter int WIDTH = 16,
   parameter int NREGS = 16,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_op_valid,
   input  logic [3:0]       i_op_code,
   input  logic [AW-1:0]    i_op_dst,
   input  logic [AW-1:0]    i_op_src,
   input  logic [WIDTH-1:0] i_op_imm,
   input  logic             i_op_use_imm,
   input  logic             i_ext_we,
   input  logic [AW-1:0]    i_ext_addr,
   input  logic [WIDTH-1:0] i_ext_data,
   input  logic [AW-1:0]    i_dbg_addr,
   output logic [WIDTH-1:0] o_dbg_data,
   output logic [WIDTH-1:0] o_result,
   output logic [4:0]       o_flags,
   output logic             o_res_valid
);
   localparam int SW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   logic [WIDTH-1:0] r_regs [NREGS];
   logic             r_ex_valid;
   logic [3:0]       r_ex_code;
   logic [AW-1:0]    r_ex_dst;
   logic [WIDTH-1:0] r_ex_a;
   logic [WIDTH-1:0] r_ex_b;
   logic             r_ex_wr;
   logic [WIDTH-1:0] r_result;
   logic [4:0]       r_flags;
   logic             r_res_valid;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_alu_res;
   logic [4:0]       w_alu_flags;
   logic             w_ovf;
   logic             w_is_sub;
   logic             w_ex_fwd;
   logic [WIDTH-1:0] w_rd_a;
   logic [WIDTH-1:0] w_rd_b;
   logic             w_rd_wr;

   // Cin comes from r_flags, which the preceding op updated at the edge this op entered EX
   always_comb begin
      w_sum     = '0;
      w_alu_res = r_ex_a;
      w_is_sub  = (r_ex_code == 4'd2) || (r_ex_code == 4'd3);
      case (r_ex_code)
         4'd0:       w_sum = {1'b0, r_ex_a} + {1'b0, r_ex_b};
         4'd1:       w_sum = {1'b0, r_ex_a} + {1'b0, r_ex_b} + {{WIDTH{1'b0}}, r_flags[4]};
         4'd2, 4'd3: w_sum = {1'b0, r_ex_a} - {1'b0, r_ex_b};
         default:    w_sum = '0;
      endcase
      case (r_ex_code)
         4'd0, 4'd1, 4'd2, 4'd3: w_alu_res = w_sum[WIDTH-1:0];
         4'd4:    w_alu_res = r_ex_a & r_ex_b;
         4'd5:    w_alu_res = r_ex_a | r_ex_b;
         4'd6:    w_alu_res = r_ex_a ^ r_ex_b;
         4'd7:    w_alu_res = r_ex_b;
         4'd8:    w_alu_res = r_ex_a << r_ex_b[SW-1:0];
         4'd9:    w_alu_res = r_ex_a >> r_ex_b[SW-1:0];
         default: w_alu_res = r_ex_a;
      endcase
      if (w_is_sub)
         w_ovf = (r_ex_a[MSB] != r_ex_b[MSB]) && (w_alu_res[MSB] != r_ex_a[MSB]);
      else
         w_ovf = (r_ex_a[MSB] == r_ex_b[MSB]) && (w_alu_res[MSB] != r_ex_a[MSB]);
      // For subtraction the top sum bit is the borrow, which is also unsigned A<B
      w_alu_flags = {w_sum[WIDTH],
                     w_is_sub & w_sum[WIDTH],
                     w_ovf,
                     (w_alu_res == '0),
                     w_is_sub & (w_alu_res[MSB] ^ w_ovf)};
   end

   always_comb begin
      w_ex_fwd = r_ex_valid && r_ex_wr;
      w_rd_a   = (w_ex_fwd && r_ex_dst == i_op_dst) ? w_alu_res : r_regs[i_op_dst];
      if (i_op_use_imm)
         w_rd_b = i_op_imm;
      else if (w_ex_fwd && r_ex_dst == i_op_src)
         w_rd_b = w_alu_res;
      else
         w_rd_b = r_regs[i_op_src];
      w_rd_wr = (i_op_code <= 4'd9) && (i_op_code != 4'd3);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         r_ex_valid  <= 1'b0;
         r_ex_code   <= '0;
         r_ex_dst    <= '0;
         r_ex_a      <= '0;
         r_ex_b      <= '0;
         r_ex_wr     <= 1'b0;
         r_result    <= '0;
         r_flags     <= '0;
         r_res_valid <= 1'b0;
      end else begin
         // EX writeback wins over an external write to the same register
         for (int i = 0; i < NREGS; i++) begin
            if (w_ex_fwd && r_ex_dst == AW'(i))
               r_regs[i] <= w_alu_res;
            else if (i_ext_we && i_ext_addr == AW'(i))
               r_regs[i] <= i_ext_data;
         end
         r_ex_valid <= i_op_valid;
         if (i_op_valid) begin
            r_ex_code <= i_op_code;
            r_ex_dst  <= i_op_dst;
            r_ex_a    <= w_rd_a;
            r_ex_b    <= w_rd_b;
            r_ex_wr   <= w_rd_wr;
         end
         r_res_valid <= r_ex_valid;
         if (r_ex_valid && r_ex_code <= 4'd9) r_result <= w_alu_res;
         if (r_ex_valid && r_ex_code <= 4'd3) r_flags <= w_alu_flags;
      end
   end

   assign o_dbg_data  = r_regs[i_dbg_addr];
   assign o_result    = r_result;
   assign o_flags     = r_flags;
   assign o_res_valid = r_res_valid;

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// tb/tb_regfile_alu_pipe.sv - scoreboard bench for regfile_alu_pipe
// Reference model executes ops in program order; expected {result,flags} queued per op.
module tb_regfile_alu_pipe;
   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_op_valid;
   logic [3:0]  i_op_code;
   logic [3:0]  i_op_dst;
   logic [3:0]  i_op_src;
   logic [15:0] i_op_imm;
   logic        i_op_use_imm;
   logic        i_ext_we;
   logic [3:0]  i_ext_addr;
   logic [15:0] i_ext_data;
   logic [3:0]  i_dbg_addr;
   logic [15:0] o_dbg_data;
   logic [15:0] o_result;
   logic [4:0]  o_flags;
   logic        o_res_valid;

   int n_pass = 0;
   int n_total = 0;

   logic [15:0] m_regs [16];
   logic [15:0] m_result;
   logic [4:0]  m_flags;
   logic        prev_wr;
   logic [3:0]  prev_dst;
   logic [20:0] q [$];

   regfile_alu_pipe #(.WIDTH(16), .NREGS(16)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_op_valid(i_op_valid), .i_op_code(i_op_code), .i_op_dst(i_op_dst),
      .i_op_src(i_op_src), .i_op_imm(i_op_imm), .i_op_use_imm(i_op_use_imm),
      .i_ext_we(i_ext_we), .i_ext_addr(i_ext_addr), .i_ext_data(i_ext_data),
      .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data),
      .o_result(o_result), .o_flags(o_flags), .o_res_valid(o_res_valid)
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      if (i_rst_n === 1'b1 && o_res_valid === 1'b1) begin
         logic [20:0] e;
         n_total++;
         if (q.size() == 0) begin
            $display("FAIL spurious_res_valid: res_valid=1 with no op outstanding");
         end else begin
            e = q.pop_front();
            if ({o_result, o_flags} !== e)
               $display("FAIL scoreboard: result=%h flags=%b expected result=%h flags=%b",
                        o_result, o_flags, e[20:5], e[4:0]);
            else
               n_pass++;
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_result = '0;
      m_flags  = '0;
      prev_wr  = 1'b0;
      prev_dst = '0;
      q.delete();
   endtask

   task automatic model_ext(input logic ew, input logic [3:0] ea, input logic [15:0] ed);
      if (ew && !(prev_wr && prev_dst == ea)) m_regs[ea] = ed;
   endtask

   task automatic idle(input logic ew = 1'b0, input logic [3:0] ea = '0, input logic [15:0] ed = '0);
      @(posedge i_clk); #1;
      i_op_valid = 1'b0;
      i_ext_we = ew; i_ext_addr = ea; i_ext_data = ed;
      model_ext(ew, ea, ed);
      prev_wr = 1'b0;
   endtask

   task automatic drive_op(input logic [3:0] code, dst, src, input logic [15:0] imm,
                           input logic use_imm, input logic ew = 1'b0,
                           input logic [3:0] ea = '0, input logic [15:0] ed = '0);
      logic [15:0] a, b, res;
      logic [4:0]  fl;
      logic        wr;
      int          ua, ub, sa, sb, s, ss;
      @(posedge i_clk); #1;
      i_op_valid = 1'b1; i_op_code = code; i_op_dst = dst; i_op_src = src;
      i_op_imm = imm; i_op_use_imm = use_imm;
      i_ext_we = ew; i_ext_addr = ea; i_ext_data = ed;
      a = m_regs[dst];
      b = use_imm ? imm : m_regs[src];
      ua = a; ub = b;
      sa = $signed(a); sb = $signed(b);
      res = m_result; fl = m_flags; wr = 1'b0;
      case (code)
         4'd0, 4'd1: begin
            s  = ua + ub + ((code == 4'd1) ? int'(m_flags[4]) : 0);
            ss = sa + sb + ((code == 4'd1) ? int'(m_flags[4]) : 0);
            res = s[15:0];
            fl = {s > 65535, 1'b0, (ss > 32767 || ss < -32768), res == 16'h0, 1'b0};
            wr = 1'b1;
         end
         4'd2, 4'd3: begin
            ss = sa - sb;
            res = a - b;
            fl = {ua < ub, ua < ub, (ss > 32767 || ss < -32768), res == 16'h0, sa < sb};
            wr = (code == 4'd2);
         end
         4'd4: begin res = a & b; wr = 1'b1; end
         4'd5: begin res = a | b; wr = 1'b1; end
         4'd6: begin res = a ^ b; wr = 1'b1; end
         4'd7: begin res = b; wr = 1'b1; end
         4'd8: begin res = a << b[3:0]; wr = 1'b1; end
         4'd9: begin res = a >> b[3:0]; wr = 1'b1; end
         default: ;
      endcase
      q.push_back({res, fl});
      m_result = res;
      m_flags  = fl;
      model_ext(ew, ea, ed);
      if (wr) m_regs[dst] = res;
      prev_wr  = wr;
      prev_dst = dst;
   endtask

   task automatic settle();
      idle(); idle(); idle();
      n_total++;
      if (q.size() != 0) $display("FAIL missing_res_valid: outstanding=%0d expected 0", q.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge i_clk); #1;
         i_op_valid = i[0]; i_op_code = 4'd7; i_op_dst = 4'(i);
         i_op_imm = 16'h1111; i_op_use_imm = 1'b1;
      end
      n_total++;
      if ({o_result, o_flags, o_res_valid} !== 22'h0)
         $display("FAIL reset_outputs: result=%h flags=%b rv=%b expected 0", o_result, o_flags, o_res_valid);
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
         i_dbg_addr = 4'(i); #1;
         n_total++;
         if (o_dbg_data !== 16'h0) $display("FAIL reset_reg r%0d=%h expected 0000", i, o_dbg_data);
         else n_pass++;
      end
      @(posedge i_clk); #1;
      i_op_valid = 1'b0; i_rst_n = 1'b1;
      model_reset();
      @(posedge i_clk); #1;
      n_total++;
      if (o_res_valid !== 1'b0) $display("FAIL release_no_res_valid: rv=%b expected 0", o_res_valid);
      else n_pass++;
   endtask

   task automatic test_add();
      idle(1'b1, 4'd1, 16'h7FFF);
      idle(1'b1, 4'd2, 16'h0001);
      drive_op(4'd0, 4'd1, 4'd2, 16'h0, 1'b0);
      idle(); idle();
      n_total++;
      if (o_res_valid !== 1'b1 || o_result !== 16'h8000 || o_flags !== 5'b00100)
         $display("FAIL add_overflow: rv=%b result=%h flags=%b expected 1 8000 00100", o_res_valid, o_result, o_flags);
      else n_pass++;
      idle();
      n_total++;
      if (o_res_valid !== 1'b0) $display("FAIL add_pulse_width: rv=%b expected 0", o_res_valid);
      else n_pass++;
      i_dbg_addr = 4'd1; #1;
      n_total++;
      if (o_dbg_data !== 16'h8000) $display("FAIL add_writeback: r1=%h expected 8000", o_dbg_data);
      else n_pass++;
      settle();
   endtask

   task automatic test_back_to_back();
      drive_op(4'd7, 4'd3, 4'd0, 16'h0005, 1'b1);
      drive_op(4'd0, 4'd3, 4'd3, 16'h0, 1'b0);
      settle();
      i_dbg_addr = 4'd3; #1;
      n_total++;
      if (o_dbg_data !== 16'h000A || o_result !== 16'h000A)
         $display("FAIL dual_forward: r3=%h result=%h expected 000a", o_dbg_data, o_result);
      else n_pass++;
   endtask

   task automatic test_cmp();
      idle(1'b1, 4'd4, 16'h0001);
      idle(1'b1, 4'd5, 16'hFFFF);
      drive_op(4'd3, 4'd4, 4'd5, 16'h0, 1'b0);
      drive_op(4'd4, 4'd4, 4'd5, 16'h0, 1'b0);
      settle();
      n_total++;
      if (o_flags !== 5'b11000 || o_result !== 16'h0001)
         $display("FAIL cmp_flags_held: flags=%b result=%h expected 11000 0001", o_flags, o_result);
      else n_pass++;
      i_dbg_addr = 4'd4; #1;
      n_total++;
      if (o_dbg_data !== 16'h0001) $display("FAIL cmp_no_writeback: r4=%h expected 0001", o_dbg_data);
      else n_pass++;
   endtask

   task automatic test_carry();
      idle(1'b1, 4'd6, 16'hFFFF);
      idle(1'b1, 4'd7, 16'hFFFF);
      drive_op(4'd2, 4'd6, 4'd7, 16'h0, 1'b0);
      drive_op(4'd1, 4'd6, 4'd0, 16'h0, 1'b1);
      drive_op(4'd0, 4'd7, 4'd0, 16'h0001, 1'b1);
      drive_op(4'd1, 4'd7, 4'd0, 16'h0, 1'b1);
      settle();
      i_dbg_addr = 4'd7; #1;
      n_total++;
      if (o_result !== 16'h0001 || o_flags !== 5'b00000 || o_dbg_data !== 16'h0001)
         $display("FAIL addc_carry_in: result=%h flags=%b r7=%h expected 0001 00000 0001", o_result, o_flags, o_dbg_data);
      else n_pass++;
   endtask

   task automatic test_collision();
      drive_op(4'd7, 4'd8, 4'd0, 16'h1234, 1'b1);
      idle(1'b1, 4'd8, 16'hBEEF);
      drive_op(4'd7, 4'd10, 4'd9, 16'h0, 1'b0, 1'b1, 4'd9, 16'h0055);
      settle();
      i_dbg_addr = 4'd8; #1;
      n_total++;
      if (o_dbg_data !== 16'h1234) $display("FAIL ex_beats_ext: r8=%h expected 1234", o_dbg_data);
      else n_pass++;
      i_dbg_addr = 4'd9; #1;
      n_total++;
      if (o_dbg_data !== 16'h0055) $display("FAIL ext_write: r9=%h expected 0055", o_dbg_data);
      else n_pass++;
      i_dbg_addr = 4'd10; #1;
      n_total++;
      if (o_dbg_data !== 16'h0000) $display("FAIL ext_not_forwarded: r10=%h expected 0000", o_dbg_data);
      else n_pass++;
   endtask

   task automatic test_shift_nop();
      idle(1'b1, 4'd11, 16'h00F0);
      drive_op(4'd8, 4'd11, 4'd0, 16'h0014, 1'b1);
      drive_op(4'd9, 4'd11, 4'd0, 16'h0008, 1'b1);
      drive_op(4'd6, 4'd12, 4'd11, 16'h0, 1'b0);
      drive_op(4'd12, 4'd11, 4'd0, 16'hFFFF, 1'b1);
      settle();
      i_dbg_addr = 4'd11; #1;
      n_total++;
      if (o_dbg_data !== 16'h000F || o_result !== 16'h000F)
         $display("FAIL shift_nop_hold: r11=%h result=%h expected 000f", o_dbg_data, o_result);
      else n_pass++;
   endtask

   task automatic test_midreset();
      drive_op(4'd7, 4'd10, 4'd0, 16'h0077, 1'b1);
      #2 i_rst_n = 1'b0;
      model_reset();
      i_dbg_addr = 4'd8; #1;
      n_total++;
      if (o_dbg_data !== 16'h0 || o_result !== 16'h0 || o_flags !== 5'b0 || o_res_valid !== 1'b0)
         $display("FAIL async_reset: r8=%h result=%h flags=%b rv=%b expected 0", o_dbg_data, o_result, o_flags, o_res_valid);
      else n_pass++;
      i_op_valid = 1'b0;
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      i_dbg_addr = 4'd10; #1;
      n_total++;
      if (o_dbg_data !== 16'h0 || o_res_valid !== 1'b0)
         $display("FAIL reset_discards_ex: r10=%h rv=%b expected 0000 0", o_dbg_data, o_res_valid);
      else n_pass++;
   endtask

   initial begin
      i_rst_n = 1'b0; i_op_valid = 1'b0; i_op_code = '0; i_op_dst = '0; i_op_src = '0;
      i_op_imm = '0; i_op_use_imm = 1'b0; i_ext_we = 1'b0; i_ext_addr = '0;
      i_ext_data = '0; i_dbg_addr = '0;
      model_reset();
      test_reset();
      test_add();
      test_back_to_back();
      test_cmp();
      test_carry();
      test_collision();
      test_shift_nop();
      test_midreset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
